// File: rtl/accel_pkg.sv
// Shared defaults and serialiser state encoding for the accelerator stream front end.
package accel_pkg;

    localparam int INSTR_W_DEF = 64;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Lane counter width; a single-lane row still needs one bit.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/accel_stream_frontend_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and a synchronous flush.
// Read data is the head entry, forced to zero while empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and count state; flush takes priority over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the array has no reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/accel_stream_frontend.sv
// Host stream front end: instruction ingress FIFO, result-row FIFO and a
// row-to-word serialiser driving a 32-bit valid/ready egress stream.
module accel_stream_frontend
    import accel_pkg::*;
#(
    parameter int ARR_SIZE    = 4,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IFIFO_DEPTH = 8,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INSTR_W-1:0]               in_instr,
    output logic                             instr_valid,
    input  logic                             instr_ready,
    output logic [INSTR_W-1:0]               instr_out,
    input  logic                             res_valid,
    output logic                             res_ready,
    input  logic [ARR_SIZE*DATA_W-1:0]       res_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_last,
    output logic                             buffer_full,
    output logic                             almost_full,
    output logic [$clog2(OFIFO_DEPTH+1)-1:0] rows_pending
);

    localparam int ICNT_W = $clog2(IFIFO_DEPTH + 1);
    localparam int LANE_W = lane_w(ARR_SIZE);
    localparam int ROW_W  = ARR_SIZE * DATA_W;

    logic              ready_en;
    logic              ififo_full;
    logic              ififo_empty;
    logic [ICNT_W-1:0] icount;
    logic              rfifo_full;
    logic              rfifo_empty;
    logic [ROW_W-1:0]  rfifo_data;
    logic              row_pop;

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [ROW_W-1:0]  row_q;
    logic [LANE_W-1:0] lane_q;
    logic              is_last;
    logic [DATA_W-1:0] lanes [ARR_SIZE];

    // Holds both ready outputs low while reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    assign in_ready     = ready_en && !ififo_full;
    assign res_ready    = ready_en && !rfifo_full;
    assign instr_valid  = !ififo_empty;
    assign buffer_full  = ififo_full;
    assign almost_full  = (icount >= ICNT_W'(IFIFO_DEPTH - 1));

    sync_fifo #(.WIDTH(INSTR_W), .DEPTH(IFIFO_DEPTH)) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (in_valid && in_ready),
        .push_data (in_instr),
        .pop       (instr_valid && instr_ready),
        .pop_data  (instr_out),
        .full      (ififo_full),
        .empty     (ififo_empty),
        .count     (icount)
    );

    sync_fifo #(.WIDTH(ROW_W), .DEPTH(OFIFO_DEPTH)) u_row_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (res_valid && res_ready),
        .push_data (res_row),
        .pop       (row_pop),
        .pop_data  (rfifo_data),
        .full      (rfifo_full),
        .empty     (rfifo_empty),
        .count     (rows_pending)
    );

    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
        assign lanes[i] = row_q[i*DATA_W +: DATA_W];
    end

    assign is_last = (lane_q == LANE_W'(ARR_SIZE - 1));

    // Serialiser state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       state_q <= IDLE;
        else if (flush) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next state: leave SEND only when the last lane goes out with nothing queued.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (!rfifo_empty) state_d = SEND;
            SEND: if (out_ready && is_last && rfifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and row FIFO pop; a finished row reloads back-to-back when another is queued.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        row_pop   = 1'b0;
        case (state_q)
            IDLE: row_pop = !rfifo_empty;
            SEND: begin
                out_valid = 1'b1;
                out_data  = lanes[lane_q];
                out_last  = is_last;
                row_pop   = out_ready && is_last && !rfifo_empty;
            end
            default: ;
        endcase
    end

    // Row register and lane counter; flush discards a partially sent row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q  <= '0;
            lane_q <= '0;
        end else if (flush) begin
            row_q  <= '0;
            lane_q <= '0;
        end else if (row_pop) begin
            row_q  <= rfifo_data;
            lane_q <= '0;
        end else if (state_q == SEND && out_ready && !is_last) begin
            lane_q <= lane_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_accel_stream_frontend.sv
// Directed testbench for accel_stream_frontend with default parameters.
module tb_accel_stream_frontend;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [63:0]  instr_out;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_row;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         buffer_full;
    logic         almost_full;
    logic [2:0]   rows_pending;

    int passed = 0;
    int total  = 0;

    accel_stream_frontend dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_row      (res_row),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .buffer_full  (buffer_full),
        .almost_full  (almost_full),
        .rows_pending (rows_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_row(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        instr_ready = 1'b0; res_valid = 1'b0; res_row = '0; out_ready = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b exp 0", in_ready); else passed++;
        total++; if (instr_valid !== 1'b0 || instr_out !== 64'd0) $display("FAIL rst_instr got v=%0b d=%h exp 0/0", instr_valid, instr_out); else passed++;
        total++; if (rows_pending !== 3'd0 || buffer_full !== 1'b0 || almost_full !== 1'b0) $display("FAIL rst_counts got rp=%0d bf=%0b af=%0b exp 0/0/0", rows_pending, buffer_full, almost_full); else passed++;
        step();
        rst = 1'b1;
        step();
        total++; if (in_ready !== 1'b1 || res_ready !== 1'b1) $display("FAIL rst_release_ready got in=%0b res=%0b exp 1/1", in_ready, res_ready); else passed++;
    endtask

    task automatic test_instr_fill_drain();
        instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = 64'hA000 + 64'(i);
            step();
            if (i == 6) begin
                total++; if (almost_full !== 1'b1 || buffer_full !== 1'b0) $display("FAIL t1_count7 got af=%0b bf=%0b exp 1/0", almost_full, buffer_full); else passed++;
            end
        end
        in_instr = 64'hA008;
        step();
        total++; if (buffer_full !== 1'b1 || almost_full !== 1'b1 || in_ready !== 1'b0) $display("FAIL t1_full got bf=%0b af=%0b rdy=%0b exp 1/1/0", buffer_full, almost_full, in_ready); else passed++;
        in_valid = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (instr_valid !== 1'b1 || instr_out !== 64'hA000 + 64'(i)) $display("FAIL t1_drain%0d got v=%0b d=%h exp 1/%h", i, instr_valid, instr_out, 64'hA000 + 64'(i)); else passed++;
            step();
        end
        instr_ready = 1'b0;
        total++; if (instr_valid !== 1'b0) $display("FAIL t1_empty got %0b exp 0", instr_valid); else passed++;
    endtask

    task automatic test_full_push_pop();
        instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = 64'hB000 + 64'(i);
            step();
        end
        in_instr = 64'hB008;
        instr_ready = 1'b1;
        step();
        in_valid = 1'b0;
        instr_ready = 1'b0;
        total++; if (buffer_full !== 1'b0 || almost_full !== 1'b1 || in_ready !== 1'b1) $display("FAIL t2_count7 got bf=%0b af=%0b rdy=%0b exp 0/1/1", buffer_full, almost_full, in_ready); else passed++;
        instr_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            total++; if (instr_out !== 64'hB000 + 64'(i)) $display("FAIL t2_drain%0d got %h exp %h", i, instr_out, 64'hB000 + 64'(i)); else passed++;
            step();
        end
        instr_ready = 1'b0;
        total++; if (instr_valid !== 1'b0) $display("FAIL t2_no_b008 got valid %0b exp 0", instr_valid); else passed++;
    endtask

    task automatic test_single_row();
        out_ready = 1'b1;
        res_valid = 1'b1;
        res_row   = {32'd4, 32'd3, 32'd2, 32'd1};
        step();
        res_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL t3_latency got out_valid %0b exp 0", out_valid); else passed++;
        step();
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 32'(i + 1) || out_last !== (i == 3)) $display("FAIL t3_word%0d got v=%0b d=%0d l=%0b exp 1/%0d/%0b", i, out_valid, out_data, out_last, i + 1, i == 3); else passed++;
            step();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL t3_idle got %0b exp 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [8];
        int w;
        for (int i = 0; i < 4; i++) begin
            exp_w[i]     = 32'd11 + 32'(i);
            exp_w[i + 4] = 32'd21 + 32'(i);
        end
        out_ready = 1'b0;
        res_valid = 1'b1;
        res_row   = mk_row(32'd11);
        step();
        res_row   = mk_row(32'd21);
        step();
        res_valid = 1'b0;
        w = 0;
        for (int c = 0; c < 20 && w < 8; c++) begin
            out_ready = (c % 2 == 0);
            total++; if (out_valid !== 1'b1 || out_data !== exp_w[w] || out_last !== (w % 4 == 3)) $display("FAIL t4_cyc%0d got v=%0b d=%0d l=%0b exp 1/%0d/%0b", c, out_valid, out_data, out_last, exp_w[w], w % 4 == 3); else passed++;
            if (out_ready) w++;
            step();
        end
        out_ready = 1'b0;
        total++; if (w != 8 || out_valid !== 1'b0) $display("FAIL t4_done got words=%0d v=%0b exp 8/0", w, out_valid); else passed++;
    endtask

    task automatic test_row_fill();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            res_valid = 1'b1;
            res_row   = mk_row(32'h100 * 32'(k + 1));
            step();
        end
        res_valid = 1'b0;
        total++; if (rows_pending !== 3'd3 || res_ready !== 1'b1) $display("FAIL t5_four got rp=%0d rdy=%0b exp 3/1", rows_pending, res_ready); else passed++;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h100) $display("FAIL t5_head got v=%0b d=%h exp 1/100", out_valid, out_data); else passed++;
        res_valid = 1'b1;
        res_row   = mk_row(32'h500);
        step();
        res_row   = mk_row(32'h600);
        step();
        res_valid = 1'b0;
        total++; if (rows_pending !== 3'd4 || res_ready !== 1'b0) $display("FAIL t5_full got rp=%0d rdy=%0b exp 4/0", rows_pending, res_ready); else passed++;
    endtask

    task automatic test_flush();
        instr_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 64'hC0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (out_data !== 32'h101 || instr_valid !== 1'b1) $display("FAIL t6_midrow got d=%h iv=%0b exp 101/1", out_data, instr_valid); else passed++;
        flush = 1'b1;
        res_valid = 1'b1;
        res_row = mk_row(32'h700);
        step();
        flush = 1'b0;
        res_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || rows_pending !== 3'd0) $display("FAIL t6_flush_out got v=%0b rp=%0d exp 0/0", out_valid, rows_pending); else passed++;
        total++; if (instr_valid !== 1'b0 || in_ready !== 1'b1 || res_ready !== 1'b1) $display("FAIL t6_flush_fifo got iv=%0b in=%0b res=%0b exp 0/1/1", instr_valid, in_ready, res_ready); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL t6_flush_stay got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_reset_midrow();
        out_ready = 1'b1;
        res_valid = 1'b1;
        res_row   = mk_row(32'h800);
        in_valid  = 1'b1;
        in_instr  = 64'hD0;
        step();
        res_valid = 1'b0;
        in_valid  = 1'b0;
        step();
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h801) $display("FAIL t7_midrow got v=%0b d=%h exp 1/801", out_valid, out_data); else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || rows_pending !== 3'd0 || instr_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL t7_async got v=%0b rp=%0d iv=%0b in=%0b exp 0/0/0/0", out_valid, rows_pending, instr_valid, in_ready); else passed++;
        step();
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        total++; if (in_ready !== 1'b1 || res_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL t7_release got in=%0b res=%0b v=%0b exp 1/1/0", in_ready, res_ready, out_valid); else passed++;
        res_valid = 1'b1;
        res_row   = mk_row(32'h900);
        step();
        res_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h900 || out_last !== 1'b0) $display("FAIL t7_recover got v=%0b d=%h l=%0b exp 1/900/0", out_valid, out_data, out_last); else passed++;
    endtask

    initial begin
        test_reset();
        test_instr_fill_drain();
        test_full_push_pop();
        test_single_row();
        test_back_to_back();
        test_row_fill();
        test_flush();
        test_reset_midrow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
